ibex_register_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the ibex core; successor to the single-write, two-read flip-flop register file.
- Adds configurable read/write port count, RV32E depth, optional write-to-read bypass, a per-register pending (scoreboard) bit for load-use tracking, and write-conflict flagging.
- Sits between ID (reads, issue) and WB (writes).

---
 rtl/ibex_regfile_pkg.sv | 29 ++
 rtl/ibex_register_file_rd_port.sv | 44 ++++
 rtl/ibex_register_file_mp.sv | 105 ++++++++++
 tb/tb_ibex_register_file_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_regfile_pkg.sv
// Shared sizing helpers and the write-request type for the multi-port register file.
package ibex_regfile_pkg;

  // Widest address (RV32I) and widest supported data path. The write request
  // type is sized to these maxima, and each instance uses only its own slice.
  localparam int MaxAddrW = 5;
  localparam int MaxDataW = 64;

  // Architectural depth of the full RV32I register file.
  localparam int NumRegs = 32;

  // Address width: 4 bits for RV32E (16 regs), 5 bits for RV32I (32 regs).
  function automatic int addr_width(input int rv32e);
    return (rv32e != 0) ? 4 : 5;
  endfunction

  // Register count for the selected base ISA.
  function automatic int num_regs(input int rv32e);
    return (rv32e != 0) ? NumRegs / 2 : NumRegs;
  endfunction

  // One write-port request. addr and data are zero-extended to the maxima.
  typedef struct packed {
    logic [MaxAddrW-1:0] addr;
    logic [MaxDataW-1:0] data;
    logic                we;
  } wr_req_t;

endpackage

// File: rtl/ibex_register_file_rd_port.sv
// One read port: x0/dummy-shadow select, optional same-cycle write bypass,
// and pending-bit lookup.
module ibex_register_file_rd_port
  import ibex_regfile_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrW        = 5,
  parameter int Depth        = 32,
  parameter int NumWrite     = 1,
  parameter int WriteBypass  = 0,
  parameter int DummyInstrEn = 1
) (
  input  logic [AddrW-1:0]                raddr_i,
  input  logic                            dummy_instr_id_i,
  input  logic [Depth-1:0][DataWidth-1:0] rf_i,
  input  logic [Depth-1:0]                pend_i,
  input  wr_req_t [NumWrite-1:0]          wreq_i,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            rpend_o
);

  // Not every instance looks at every request bit (no bypass, narrow data).
  logic unused_wreq;
  assign unused_wreq = ^wreq_i;

  // Stored value first, then x0 override, then bypass (highest port last so it wins).
  always_comb begin
    rdata_o = rf_i[raddr_i];
    rpend_o = pend_i[raddr_i];
    if (raddr_i == '0) begin
      // Entry 0 holds the dummy shadow; visible only while a dummy is in ID.
      rdata_o = ((DummyInstrEn != 0) && dummy_instr_id_i) ? rf_i[0] : '0;
      rpend_o = 1'b0;
    end else if (WriteBypass != 0) begin
      for (int k = 0; k < NumWrite; k++) begin
        if (wreq_i[k].we && (wreq_i[k].addr == MaxAddrW'(raddr_i))) begin
          rdata_o = wreq_i[k].data[DataWidth-1:0];
          rpend_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ibex_register_file_mp.sv
// Multi-port integer register file: NumWrite write ports, NumRead read ports,
// per-register pending bits for load-use tracking and a dual-write conflict flag.
module ibex_register_file_mp
  import ibex_regfile_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RV32E        = 0,
  parameter int NumRead      = 2,
  parameter int NumWrite     = 1,
  parameter int WriteBypass  = 0,
  parameter int DummyInstrEn = 1,
  localparam int AddrW       = addr_width(RV32E)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          test_en_i,
  input  logic                          dummy_instr_id_i,
  input  logic [NumRead*AddrW-1:0]      raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rpend_o,
  input  logic [NumWrite*AddrW-1:0]     waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          pend_set_i,
  input  logic [AddrW-1:0]              pend_addr_i,
  output logic                          wr_conflict_o
);

  localparam int Depth = num_regs(RV32E);

  wr_req_t [NumWrite-1:0]          wreq;
  // Entry 0 is the dummy-instruction shadow of x0, never an architectural x0.
  logic [Depth-1:0][DataWidth-1:0] rf_q;
  logic [Depth-1:0]                pend_q;
  logic                            conflict_q;

  // test_en_i only matters for a latch/clock-gated variant.
  logic unused_in;
  assign unused_in = ^{test_en_i, wreq};

  for (genvar k = 0; k < NumWrite; k++) begin : g_wreq
    assign wreq[k] = '{addr: MaxAddrW'(waddr_i[k*AddrW +: AddrW]),
                       data: MaxDataW'(wdata_i[k*DataWidth +: DataWidth]),
                       we:   we_i[k]};
  end

  // Register writes; later ports override earlier ones, x0 writes hit the shadow only for dummies.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_q <= '0;
    end else begin
      for (int k = 0; k < NumWrite; k++) begin
        if (wreq[k].we &&
            ((wreq[k].addr != '0) || ((DummyInstrEn != 0) && dummy_instr_id_i))) begin
          rf_q[wreq[k].addr[AddrW-1:0]] <= wreq[k].data[DataWidth-1:0];
        end
      end
    end
  end

  // Scoreboard: writes clear, issue sets; set is applied last so a new producer wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      for (int k = 0; k < NumWrite; k++) begin
        if (wreq[k].we) pend_q[wreq[k].addr[AddrW-1:0]] <= 1'b0;
      end
      if (pend_set_i && (pend_addr_i != '0)) pend_q[pend_addr_i] <= 1'b1;
    end
  end

  if (NumWrite == 2) begin : g_conflict
    // Flag one cycle after both ports target the same non-zero register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) conflict_q <= 1'b0;
      else       conflict_q <= wreq[0].we && wreq[1].we &&
                               (wreq[0].addr == wreq[1].addr) && (wreq[1].addr != '0);
    end
  end else begin : g_no_conflict
    assign conflict_q = 1'b0;
  end

  assign wr_conflict_o = conflict_q;

  for (genvar r = 0; r < NumRead; r++) begin : g_rd
    ibex_register_file_rd_port #(
      .DataWidth   (DataWidth),
      .AddrW       (AddrW),
      .Depth       (Depth),
      .NumWrite    (NumWrite),
      .WriteBypass (WriteBypass),
      .DummyInstrEn(DummyInstrEn)
    ) u_rd (
      .raddr_i         (raddr_i[r*AddrW +: AddrW]),
      .dummy_instr_id_i(dummy_instr_id_i),
      .rf_i            (rf_q),
      .pend_i          (pend_q),
      .wreq_i          (wreq),
      .rdata_o         (rdata_o[r*DataWidth +: DataWidth]),
      .rpend_o         (rpend_o[r])
    );
  end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Bench: two configurations driven with shared stimulus.
//   A: RV32I, 2 read, 2 write, no bypass.   B: RV32E, 2 read, 2 write, bypass.
// Both are compared every cycle against an array-based model of the register file.
module tb_ibex_register_file_mp;

  logic clk = 1'b0;
  logic rst;
  logic test_en = 1'b0;
  logic dummy;
  logic [1:0][4:0]  ra;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0]       we;
  logic             ps;
  logic [4:0]       pa;

  logic [1:0][31:0] rd_a, rd_b;
  logic [1:0]       rp_a, rp_b;
  logic             cf_a, cf_b;

  always #5 clk = ~clk;

  ibex_register_file_mp #(.RV32E(0), .NumRead(2), .NumWrite(2), .WriteBypass(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .dummy_instr_id_i(dummy),
    .raddr_i(ra), .rdata_o(rd_a), .rpend_o(rp_a),
    .waddr_i(wa), .wdata_i(wd), .we_i(we),
    .pend_set_i(ps), .pend_addr_i(pa), .wr_conflict_o(cf_a)
  );

  ibex_register_file_mp #(.RV32E(1), .NumRead(2), .NumWrite(2), .WriteBypass(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .dummy_instr_id_i(dummy),
    .raddr_i({ra[1][3:0], ra[0][3:0]}), .rdata_o(rd_b), .rpend_o(rp_b),
    .waddr_i({wa[1][3:0], wa[0][3:0]}), .wdata_i(wd), .we_i(we),
    .pend_set_i(ps), .pend_addr_i(pa[3:0]), .wr_conflict_o(cf_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: index 0 of m_rf is the dummy shadow.
  logic [31:0] m_rf [2][32];
  bit          m_pd [2][32];
  bit          m_cf [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic int amask(input int i);
    return (i == 1) ? 15 : 31;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 32; a++) begin
        m_rf[i][a] = '0;
        m_pd[i][a] = 1'b0;
      end
      m_cf[i] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int a0, a1, pm;
      a0 = wa[0] & amask(i);
      a1 = wa[1] & amask(i);
      for (int k = 0; k < 2; k++) begin
        int a;
        a = wa[k] & amask(i);
        if (we[k]) begin
          if (a != 0 || dummy) m_rf[i][a] = wd[k];
          m_pd[i][a] = 1'b0;
        end
      end
      pm = pa & amask(i);
      if (ps && pm != 0) m_pd[i][pm] = 1'b1;
      m_cf[i] = we[0] && we[1] && (a0 == a1) && (a1 != 0);
    end
  endtask

  // Compare every output of both instances with the model.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        int a;
        logic [31:0] ev;
        bit ep;
        a = ra[r] & amask(i);
        if (a == 0) begin
          ev = dummy ? m_rf[i][0] : 32'h0;
          ep = 1'b0;
        end else begin
          ev = m_rf[i][a];
          ep = m_pd[i][a];
          if (i == 1) begin
            for (int k = 0; k < 2; k++) begin
              if (we[k] && ((wa[k] & amask(i)) == a)) begin
                ev = wd[k];
                ep = 1'b0;
              end
            end
          end
        end
        chk($sformatf("rdata%s%0d", (i == 1) ? "_b" : "_a", r), (i == 1) ? rd_b[r] : rd_a[r], ev);
        chk($sformatf("rpend%s%0d", (i == 1) ? "_b" : "_a", r),
            32'((i == 1) ? rp_b[r] : rp_a[r]), 32'(ep));
      end
      chk((i == 1) ? "conflict_b" : "conflict_a", 32'((i == 1) ? cf_b : cf_a), 32'(m_cf[i]));
    end
  endtask

  // Called right after a negedge drive: check, take the edge, return at the next negedge.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = '0;
    ps = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dummy = 1'b0; ra = '0; wa = '0; wd = '0; we = '0; ps = 1'b0; pa = '0;
    model_clear();
    ra[0] = 5'd2; ra[1] = 5'd3;
    #2;
    chk("rst_rd_a0", rd_a[0], 32'h0);
    chk("rst_rpend_a", 32'(rp_a), 32'h0);
    chk("rst_conflict_b", 32'(cf_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read.
    we = 2'b01; wa[0] = 5'd2; wd[0] = 32'hDEADBEEF; cyc();
    wa[0] = 5'd3; wd[0] = 32'h0BADC0DE; cyc();
    idle(); ra[0] = 5'd2; ra[1] = 5'd3;
    #1;
    chk("basic_a_x2", rd_a[0], 32'hDEADBEEF);
    chk("basic_a_x3", rd_a[1], 32'h0BADC0DE);
    chk("basic_b_x3", rd_b[1], 32'h0BADC0DE);
    chk("basic_rpend", 32'({rp_a, rp_b}), 32'h0);
    cyc();
    we = 2'b01; wa[0] = 5'd15; wd[0] = 32'h15151515; cyc();
    idle(); ra[0] = 5'd15;
    #1 chk("basic_b_x15", rd_b[0], 32'h15151515);
    cyc();

    // x0 and dummy shadow.
    dummy = 1'b0; we = 2'b01; wa[0] = 5'd0; wd[0] = 32'h12345678; cyc();
    idle(); ra[0] = 5'd0;
    #1 chk("x0_nodummy", rd_a[0], 32'h0);
    cyc();
    dummy = 1'b1; we = 2'b01; cyc();
    idle();
    #1 chk("x0_dummy_a", rd_a[0], 32'h12345678);
    chk("x0_dummy_b", rd_b[0], 32'h12345678);
    cyc();
    dummy = 1'b0;
    #1 chk("x0_dummy_off", rd_a[0], 32'h0);
    cyc();

    // Same-cycle bypass (B only).
    we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hA5A5A5A5; ra[0] = 5'd5;
    #1 chk("bypass_b", rd_b[0], 32'hA5A5A5A5);
    chk("no_bypass_a", rd_a[0], 32'h0);
    cyc();
    idle();

    // Dual-write conflict: port 1 wins, flag for one cycle.
    we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h1; wd[1] = 32'h2; cyc();
    idle(); ra[0] = 5'd7;
    #1 chk("conflict_data", rd_a[0], 32'h2);
    chk("conflict_hi", 32'({cf_a, cf_b}), 32'h3);
    cyc();
    #1 chk("conflict_lo", 32'({cf_a, cf_b}), 32'h0);
    cyc();
    we = 2'b11; wa[0] = 5'd0; wa[1] = 5'd0; cyc();
    idle();
    #1 chk("conflict_x0", 32'({cf_a, cf_b}), 32'h0);
    cyc();

    // Scoreboard.
    ps = 1'b1; pa = 5'd9; ra[0] = 5'd0; cyc();
    idle(); ra[0] = 5'd9;
    #1 chk("pend_set", 32'({rp_a[0], rp_b[0]}), 32'h3);
    cyc();
    ra[0] = 5'd0; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h99; ps = 1'b1; pa = 5'd9; cyc();
    idle(); ra[0] = 5'd9;
    #1 chk("pend_set_wins", 32'({rp_a[0], rp_b[0]}), 32'h3);
    cyc();
    ra[0] = 5'd0; we = 2'b01; wa[0] = 5'd9; cyc();
    idle(); ra[0] = 5'd9;
    #1 chk("pend_clear", 32'({rp_a[0], rp_b[0]}), 32'h0);
    cyc();

    // Asynchronous reset between edges; a write during reset is lost.
    ra[0] = 5'd0; we = 2'b01; wa[0] = 5'd4; wd[0] = 32'h0000FFFF; ps = 1'b1; pa = 5'd9; cyc();
    idle(); ra[0] = 5'd4; ra[1] = 5'd9;
    #1 chk("pre_rst_x4", rd_a[0], 32'h0000FFFF);
    chk("pre_rst_pend", 32'(rp_a[1]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", rd_a[0], 32'h0);
    chk("async_rst_b", rd_b[0], 32'h0);
    chk("async_rst_pend", 32'({rp_a, rp_b}), 32'h0);
    model_clear();
    we = 2'b01; wa[0] = 5'd6; wd[0] = 32'h66666666;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0; idle(); ra[0] = 5'd6;
    cyc();

    // Randomized traffic, biased toward address collisions.
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        wa[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wd[k] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
      we = 2'($urandom);
      for (int r = 0; r < 2; r++)
        ra[r] = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 9));
      dummy = ($urandom_range(0, 3) == 0);
      ps = $urandom_range(0, 1);
      pa = ($urandom_range(0, 1) == 0) ? wa[0] : 5'($urandom_range(0, 9));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
